// File: rtl/sccb_master_rw.sv
// SCCB master for OV7670-class camera setup: 8/16-bit register address, programmable SIO_C rate, ACK status.
// Optional read path (GAP, ID+R, read byte, NA) is compiled in when SCCB_READ_EN is defined.
module sccb_master_rw #(
  parameter int         CLK_DIV  = 4,
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter int         REG_AW   = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_data,
  output logic              ack_err,
  output logic              sio_c,
  inout  wire               sio_d
);
  // state   | meaning
  // S_IDLE  | bus released, waiting for req
  // S_START | start condition, 4 ticks
  // S_PHASE | one bit of a 9-bit phase per element (ph = phase index)
  // S_STOP  | stop condition, 4 ticks
  // S_GAP   | bus idle between write-address and read segments
  // S_DONE  | single-cycle completion
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_PHASE, S_STOP,
`ifdef SCCB_READ_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  localparam int AB = REG_AW / 8;
  localparam int DW = $clog2(CLK_DIV);

  state_t            state, state_n;
  logic [DW-1:0]     div_cnt;
  logic [1:0]        q;
  logic [3:0]        bitn;
  logic [1:0]        ph;
  logic [REG_AW-1:0] addr_l;
  logic [7:0]        data_l;
  logic [15:0]       addr_ext;
  logic [7:0]        tx_byte;
  logic [7:0]        rd_sh;
  logic [1:0]        sd_sync;
  logic              tick, el_end, last_ph, rd_phase;
  logic              c_n, oe_n, do_n, d_oe, d_out;

  assign tick     = (div_cnt == '0);
  assign el_end   = tick && (q == 2'd3);
  assign addr_ext = 16'(addr_l);
  assign sio_d    = d_oe ? d_out : 1'bz;

`ifdef SCCB_READ_EN
  logic rw_l, second;
  assign rd_phase = second && (ph == 2'd1);
  assign last_ph  = second ? (ph == 2'd1) : (ph == (rw_l ? 2'(AB) : 2'(AB + 1)));
`else
  logic unused_rw;
  assign unused_rw = rw;
  assign rd_phase  = 1'b0;
  assign last_ph   = (ph == 2'(AB + 1));
  assign rd_data   = 8'h00;
`endif

  always_comb begin
    tx_byte = data_l;
    if (ph == 2'd0) begin
`ifdef SCCB_READ_EN
      tx_byte = {DEV_ADDR, second};
`else
      tx_byte = {DEV_ADDR, 1'b0};
`endif
    end else if (AB == 2 && ph == 2'd1) tx_byte = addr_ext[15:8];
    else if (ph <= 2'(AB))             tx_byte = addr_ext[7:0];
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    c_n     = 1'b1;
    oe_n    = 1'b0;
    do_n    = 1'b1;
    case (state)
      S_IDLE:  if (req) state_n = S_START;
      S_START: begin
        oe_n = 1'b1;
        c_n  = (q < 2'd2);
        do_n = (q == 2'd0);
        if (el_end) state_n = S_PHASE;
      end
      S_PHASE: begin
        c_n  = (q == 2'd1) || (q == 2'd2);
        // 9th bit is released for slave ACK, except master NA after the read byte
        oe_n = (bitn == 4'd8) ? rd_phase : !rd_phase;
        do_n = (bitn == 4'd8) ? 1'b1 : tx_byte[3'd7 - bitn[2:0]];
        if (el_end && bitn == 4'd8 && last_ph) state_n = S_STOP;
      end
      S_STOP: begin
        oe_n = 1'b1;
        c_n  = (q != 2'd0);
        do_n = (q >= 2'd2);
`ifdef SCCB_READ_EN
        if (el_end) state_n = (rw_l && !second) ? S_GAP : S_DONE;
      end
      S_GAP: begin
        if (el_end) state_n = S_START;
`else
        if (el_end) state_n = S_DONE;
`endif
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      sd_sync <= 2'b11;
      sio_c   <= 1'b1;
      d_oe    <= 1'b0;
      d_out   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      div_cnt <= '0;
      q       <= 2'd0;
      bitn    <= 4'd0;
      ph      <= 2'd0;
      addr_l  <= '0;
      data_l  <= 8'h00;
      rd_sh   <= 8'h00;
`ifdef SCCB_READ_EN
      rw_l    <= 1'b0;
      second  <= 1'b0;
      rd_data <= 8'h00;
`endif
    end else begin
      sd_sync <= {sd_sync[0], sio_d};
      sio_c   <= c_n;
      d_oe    <= oe_n;
      d_out   <= do_n;
      done    <= (state == S_DONE);
      if (state == S_IDLE) begin
        if (req) begin
          addr_l  <= reg_addr;
          data_l  <= wr_data;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          div_cnt <= DW'(CLK_DIV - 1);
          q       <= 2'd0;
          bitn    <= 4'd0;
          ph      <= 2'd0;
`ifdef SCCB_READ_EN
          rw_l    <= rw;
          second  <= 1'b0;
`endif
        end
      end else begin
        if (tick) begin
          div_cnt <= DW'(CLK_DIV - 1);
          q       <= q + 2'd1;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
        if (state == S_PHASE && tick && q == 2'd2) begin
          if (bitn == 4'd8 && !rd_phase) ack_err <= ack_err | sd_sync[1];
          if (bitn != 4'd8 && rd_phase)  rd_sh   <= {rd_sh[6:0], sd_sync[1]};
        end
        if (state == S_START && el_end) begin
          bitn <= 4'd0;
          ph   <= 2'd0;
        end
        if (state == S_PHASE && el_end) begin
          if (bitn == 4'd8) begin
            bitn <= 4'd0;
            ph   <= ph + 2'd1;
          end else begin
            bitn <= bitn + 4'd1;
          end
        end
`ifdef SCCB_READ_EN
        if (state == S_GAP && el_end) second <= 1'b1;
        if (state == S_DONE && rw_l)  rd_data <= rd_sh;
`endif
        if (state == S_DONE) busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sccb_master_rw.sv
// Bench for sccb_master_rw: bus monitor + slave model feed a token scoreboard (START, bytes, 9th bits, STOP).
module tb_sccb_master_rw;
  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 10;
  localparam int ACK_DLY = CLK_DIV * PERIOD * 3 / 2;
  localparam int TOK_S   = 'h100;
  localparam int TOK_P   = 'h200;
  localparam int TOK_A   = 'h300;

  logic        sclk = 1'b0, rst = 1'b1, req8 = 1'b0, req16 = 1'b0, rw = 1'b0;
  logic [7:0]  addr8 = 8'h00, wr_data = 8'h00;
  logic [15:0] addr16 = 16'h0000;
  logic        busy8, done8, ae8, c8, busy16, done16, ae16, c16;
  logic [7:0]  rd8, rd16;
  wire         sio_d;
  wire         bus_c;

  int          n_chk = 0, n_pass = 0;
  int          exp_q[$], obs_q[$];
  int          nack_idx = -1;
  logic [7:0]  rd_val = 8'h00;

  always #(PERIOD / 2) sclk = ~sclk;

  sccb_master_rw #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h21), .REG_AW(8)) u8 (
    .sclk(sclk), .rst(rst), .req(req8), .rw(rw), .reg_addr(addr8), .wr_data(wr_data),
    .busy(busy8), .done(done8), .rd_data(rd8), .ack_err(ae8), .sio_c(c8), .sio_d(sio_d));
  sccb_master_rw #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h21), .REG_AW(16)) u16 (
    .sclk(sclk), .rst(rst), .req(req16), .rw(rw), .reg_addr(addr16), .wr_data(wr_data),
    .busy(busy16), .done(done16), .rd_data(rd16), .ack_err(ae16), .sio_c(c16), .sio_d(sio_d));

  // the idle master holds sio_c high and releases sio_d, so both share one bus
  assign bus_c = c8 & c16;
  logic want = 1'b0, slv_drv = 1'b0;
  assign sio_d = slv_drv ? 1'b0 : 1'bz;
  pullup (sio_d);

  always @(want) begin
    if (!want) slv_drv = 1'b0;
    else begin
      #(ACK_DLY);
      slv_drv = want;
    end
  end

  logic       pc = 1'b1, pd = 1'b1, got9 = 1'b0, rmode = 1'b0;
  logic [7:0] sh = 8'h00, last_b = 8'h00;
  int         mbit = 0, bidx = 0;
  always @(bus_c or sio_d or rst) begin
    if (rst) begin
      mbit = 0; got9 = 1'b0; rmode = 1'b0; want = 1'b0; bidx = 0;
    end else if (pc === 1'b1 && bus_c === 1'b1 && pd === 1'b1 && sio_d === 1'b0) begin
      obs_q.push_back(TOK_S);
      mbit = 0; got9 = 1'b0; rmode = 1'b0; bidx = 0;
    end else if (pc === 1'b1 && bus_c === 1'b1 && pd === 1'b0 && sio_d === 1'b1) begin
      obs_q.push_back(TOK_P);
    end else if (pc === 1'b0 && bus_c === 1'b1) begin
      if (mbit < 8) begin
        sh = {sh[6:0], sio_d};
        mbit++;
        if (mbit == 8) begin
          obs_q.push_back(int'(sh));
          last_b = sh;
        end
      end else begin
        obs_q.push_back(TOK_A | int'(sio_d));
        mbit = 0;
        got9 = 1'b1;
      end
    end else if (pc === 1'b1 && bus_c === 1'b0) begin
      if (got9) begin
        got9 = 1'b0;
        bidx++;
        if (rmode) begin
          rmode = 1'b0; want = 1'b0;
        end else if (last_b == 8'h43) begin
          rmode = 1'b1; want = ~rd_val[7];
        end else want = 1'b0;
      end else if (mbit == 8) begin
        want = !rmode && (bidx != nack_idx);
      end else if (rmode && mbit >= 1 && mbit <= 7) begin
        want = ~rd_val[7-mbit];
      end
    end
    pc = bus_c;
    pd = sio_d;
  end

  task automatic push_write(input bit w16, input logic [15:0] a, input logic [7:0] d, input int nk);
    exp_q.push_back(TOK_S);
    exp_q.push_back('h42); exp_q.push_back(TOK_A | int'(nk == 0));
    if (w16) begin
      exp_q.push_back(int'(a[15:8])); exp_q.push_back(TOK_A | int'(nk == 1));
      exp_q.push_back(int'(a[7:0]));  exp_q.push_back(TOK_A | int'(nk == 2));
      exp_q.push_back(int'(d));       exp_q.push_back(TOK_A | int'(nk == 3));
    end else begin
      exp_q.push_back(int'(a[7:0]));  exp_q.push_back(TOK_A | int'(nk == 1));
      exp_q.push_back(int'(d));       exp_q.push_back(TOK_A | int'(nk == 2));
    end
    exp_q.push_back(TOK_P);
  endtask

  task automatic txn(input bit use16, input bit rw_i, input logic [15:0] a, input logic [7:0] d,
                     output int cyc, output logic ae, output logic [7:0] rd,
                     output logic bsy_acc, output logic bsy_done, output logic dn_after);
    rw = rw_i; addr8 = a[7:0]; addr16 = a; wr_data = d;
    if (use16) req16 = 1'b1; else req8 = 1'b1;
    @(posedge sclk); #1;
    req8 = 1'b0; req16 = 1'b0;
    bsy_acc = use16 ? busy16 : busy8;
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge sclk); #1;
      if ((use16 ? done16 : done8) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    ae = use16 ? ae16 : ae8;
    rd = use16 ? rd16 : rd8;
    bsy_done = use16 ? busy16 : busy8;
    @(posedge sclk); #1;
    dn_after = use16 ? done16 : done8;
  endtask

  task automatic test_reset();
    n_chk++; if (busy8 !== 1'b0) $display("FAIL reset busy8 got %b required 0", busy8); else n_pass++;
    n_chk++; if (done8 !== 1'b0) $display("FAIL reset done8 got %b required 0", done8); else n_pass++;
    n_chk++; if (rd8 !== 8'h00) $display("FAIL reset rd_data got %h required 00", rd8); else n_pass++;
    n_chk++; if (ae8 !== 1'b0) $display("FAIL reset ack_err got %b required 0", ae8); else n_pass++;
    n_chk++; if (c8 !== 1'b1 || c16 !== 1'b1) $display("FAIL reset sio_c got %b%b required 11", c8, c16); else n_pass++;
    n_chk++; if (sio_d !== 1'b1) $display("FAIL reset sio_d got %b required released(1)", sio_d); else n_pass++;
    n_chk++; if (busy16 !== 1'b0 || done16 !== 1'b0) $display("FAIL reset u16 busy/done got %b%b required 00", busy16, done16); else n_pass++;
  endtask

  task automatic test_write8();
    int cyc, e, g; logic ae, ba, bd, da; logic [7:0] rd;
    nack_idx = -1;
    push_write(1'b0, 16'h0012, 8'h80, -1);
    txn(1'b0, 1'b0, 16'h0012, 8'h80, cyc, ae, rd, ba, bd, da);
    n_chk++; if (ba !== 1'b1) $display("FAIL write8 busy after accept got %b required 1", ba); else n_pass++;
    n_chk++; if (cyc != 465) $display("FAIL write8 latency got %0d required 465", cyc); else n_pass++;
    n_chk++; if (ae !== 1'b0) $display("FAIL write8 ack_err got %b required 0", ae); else n_pass++;
    n_chk++; if (bd !== 1'b0) $display("FAIL write8 busy at done got %b required 0", bd); else n_pass++;
    n_chk++; if (da !== 1'b0) $display("FAIL write8 done width got %b after pulse required 0", da); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_chk++; if (g !== e) $display("FAIL write8 bus token got %0h required %0h", g, e); else n_pass++;
    end
    n_chk++; if (obs_q.size() != 0) $display("FAIL write8 extra tokens got %0d required 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_nack();
    int cyc, e, g; logic ae, ba, bd, da; logic [7:0] rd;
    nack_idx = 2;
    push_write(1'b0, 16'h0012, 8'h80, 2);
    txn(1'b0, 1'b0, 16'h0012, 8'h80, cyc, ae, rd, ba, bd, da);
    n_chk++; if (cyc != 465) $display("FAIL nack latency got %0d required 465", cyc); else n_pass++;
    n_chk++; if (ae !== 1'b1) $display("FAIL nack ack_err got %b required 1", ae); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_chk++; if (g !== e) $display("FAIL nack bus token got %0h required %0h", g, e); else n_pass++;
    end
    nack_idx = -1;
  endtask

  task automatic test_write16();
    int cyc, e, g; logic ae, ba, bd, da; logic [7:0] rd;
    push_write(1'b1, 16'h3008, 8'h82, -1);
    txn(1'b1, 1'b0, 16'h3008, 8'h82, cyc, ae, rd, ba, bd, da);
    n_chk++; if (cyc != 609) $display("FAIL write16 latency got %0d required 609", cyc); else n_pass++;
    n_chk++; if (ae !== 1'b0) $display("FAIL write16 ack_err got %b required 0", ae); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_chk++; if (g !== e) $display("FAIL write16 bus token got %0h required %0h", g, e); else n_pass++;
    end
  endtask

  task automatic test_read();
    int cyc, e, g; logic ae, ba, bd, da; logic [7:0] rd;
    rd_val = 8'h76;
`ifdef SCCB_READ_EN
    exp_q.push_back(TOK_S); exp_q.push_back('h42); exp_q.push_back(TOK_A);
    exp_q.push_back('h0A);  exp_q.push_back(TOK_A); exp_q.push_back(TOK_P);
    exp_q.push_back(TOK_S); exp_q.push_back('h43); exp_q.push_back(TOK_A);
    exp_q.push_back('h76);  exp_q.push_back(TOK_A | 1); exp_q.push_back(TOK_P);
    txn(1'b0, 1'b1, 16'h000A, 8'h55, cyc, ae, rd, ba, bd, da);
    n_chk++; if (cyc != 657) $display("FAIL read latency got %0d required 657", cyc); else n_pass++;
    n_chk++; if (rd !== 8'h76) $display("FAIL read rd_data got %h required 76", rd); else n_pass++;
`else
    push_write(1'b0, 16'h000A, 8'h55, -1);
    txn(1'b0, 1'b1, 16'h000A, 8'h55, cyc, ae, rd, ba, bd, da);
    n_chk++; if (cyc != 465) $display("FAIL read_disabled latency got %0d required 465", cyc); else n_pass++;
    n_chk++; if (rd !== 8'h00) $display("FAIL read_disabled rd_data got %h required 00", rd); else n_pass++;
`endif
    n_chk++; if (ae !== 1'b0) $display("FAIL read ack_err got %b required 0", ae); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_chk++; if (g !== e) $display("FAIL read bus token got %0h required %0h", g, e); else n_pass++;
    end
    rd_val = 8'h00;
  endtask

  task automatic test_rst_abort();
    int cyc, e, g; logic ae, ba, bd, da; logic [7:0] rd;
    rw = 1'b0; addr8 = 8'h11; wr_data = 8'h01; req8 = 1'b1;
    @(posedge sclk); #1;
    req8 = 1'b0;
    repeat (200) @(posedge sclk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (c8 !== 1'b1) $display("FAIL abort sio_c got %b required 1", c8); else n_pass++;
    n_chk++; if (sio_d !== 1'b1) $display("FAIL abort sio_d got %b required released(1)", sio_d); else n_pass++;
    n_chk++; if (busy8 !== 1'b0) $display("FAIL abort busy got %b required 0", busy8); else n_pass++;
    repeat (3) @(posedge sclk);
    #1 rst = 1'b0;
    #(ACK_DLY + PERIOD);
    obs_q.delete();
    exp_q.delete();
    @(posedge sclk); #1;
    push_write(1'b0, 16'h0011, 8'h01, -1);
    txn(1'b0, 1'b0, 16'h0011, 8'h01, cyc, ae, rd, ba, bd, da);
    n_chk++; if (cyc != 465) $display("FAIL abort next latency got %0d required 465", cyc); else n_pass++;
    n_chk++; if (ae !== 1'b0) $display("FAIL abort next ack_err got %b required 0", ae); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_chk++; if (g !== e) $display("FAIL abort next bus token got %0h required %0h", g, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc, e, g;
    push_write(1'b0, 16'h0021, 8'h5A, -1);
    push_write(1'b0, 16'h0021, 8'hC3, -1);
    rw = 1'b0; addr8 = 8'h21; wr_data = 8'h5A; req8 = 1'b1;
    @(posedge sclk); #1;
    wr_data = 8'hC3;
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge sclk); #1;
      if (done8 === 1'b1) begin cyc = i; break; end
    end
    n_chk++; if (cyc != 465) $display("FAIL b2b first latency got %0d required 465", cyc); else n_pass++;
    n_chk++; if (busy8 !== 1'b0) $display("FAIL b2b busy at done got %b required 0", busy8); else n_pass++;
    @(posedge sclk); #1;
    req8 = 1'b0;
    n_chk++; if (busy8 !== 1'b1 || done8 !== 1'b0) $display("FAIL b2b second accept busy/done got %b%b required 10", busy8, done8); else n_pass++;
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge sclk); #1;
      if (done8 === 1'b1) begin cyc = i; break; end
    end
    n_chk++; if (cyc != 465) $display("FAIL b2b second latency got %0d required 465", cyc); else n_pass++;
    repeat (4) @(posedge sclk);
    #1;
    n_chk++; if (busy8 !== 1'b0) $display("FAIL b2b idle after req drop got %b required 0", busy8); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_chk++; if (g !== e) $display("FAIL b2b bus token got %0h required %0h", g, e); else n_pass++;
    end
    n_chk++; if (obs_q.size() != 0) $display("FAIL b2b extra tokens got %0d required 0", obs_q.size()); else n_pass++;
  endtask

  initial begin
    repeat (3) @(posedge sclk);
    #1;
    test_reset();
    rst = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    test_reset();
    test_write8();
    test_nack();
    test_write16();
    test_read();
    test_rst_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sccb_master_rw.md
# sccb_master_rw

Parametrised SCCB master for OV7670-class camera configuration: the next generation of the write-only SCCB block, adding 8/16-bit register addressing, a programmable SIO_C rate, read transactions and a per-phase ACK status. It sits between the register-init sequencer (ROM walker) and the camera pins, accepts one transaction per request and reports completion with a single-cycle pulse.

## Interface
- CLK_DIV, 4: sclk cycles per quarter SIO_C period (tick); legal ≥2
- DEV_ADDR, 7'h21: 7-bit SCCB device ID (write byte 0x42, read byte 0x43)
- REG_AW, 8: register address width, 8 or 16

- sclk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  transaction request; sampled only in IDLE
- rw  in  1  0 = write, 1 = read
- reg_addr  in  REG_AW  register address; MSB byte first when 16
- wr_data  in  8  write payload
- busy  out  1  high from cycle after accept until done
- done  out  1  one-cycle completion pulse
- rd_data  out  8  read result, valid from done until next done
- ack_err  out  1  OR of all sampled 9th bits (1 = no ACK), valid at done
- sio_c  out  1  SCCB clock
- sio_d  inout  1  SCCB data; driven low/high or released (Z)

## Operation
- Reset values: busy 0, done 0, rd_data 0, ack_err 0, sio_c 1, sio_d released; state IDLE.
- IDLE: req=1 latches rw, reg_addr, wr_data; clears ack_err; tick counter cleared; enter START. req while busy ignored.
- Tick every CLK_DIV sclk cycles; every bus element lasts 4 ticks (t0–t3).
- START: t0 sio_c=1,sio_d=1; t1 sio_d=0; t2 sio_c=0; t3 hold.
- Bit: t0 update sio_d (sio_c low); t1 sio_c=1; t2 sample sio_d (read/ACK); t3 sio_c=0. Data MSB first.
- Phase = 8 data bits + 9th bit. Write phases: 9th bit released, sampled into ack_err (OR).
- STOP: t0 sio_d=0; t1 sio_c=1; t2 sio_d=1; t3 hold; then released.
- Write: START, ID+W, addr byte(s), wr_data, STOP, DONE.
- Read: START, ID+W, addr byte(s), STOP, GAP (4 ticks bus idle), START, ID+R, read 8 bits (released), 9th bit master drives 1 (NA), STOP, DONE.
- DONE: done=1 one cycle, busy=0 same cycle, return to IDLE; rd_data updated on read only.
- FSM: IDLE → START → PHASE(n) → STOP → [GAP → START → PHASE_ID_R → PHASE_RD → STOP] → DONE → IDLE.

## Timing
- Accept edge to done: N·CLK_DIV + 1 sclk cycles; N ticks = 116 (write, 8-bit addr), 152 (write, 16-bit), 164 (read, 8-bit), 200 (read, 16-bit).
- New req accepted earliest in the cycle after done (back-to-back allowed).
- sio_d changes only while sio_c low, except START/STOP edges.
- rst mid-transaction: immediate abort to reset values; no STOP issued; next req starts clean.
- Inputs are don't-care after acceptance.

## Configuration
- SCCB_READ_EN defined: read path (GAP, ID+R, read byte, NA) compiled in; rw honoured.
- Undefined: rw ignored, every transaction is a write, rd_data tied 0, read states absent.

## Test plan
- Write, defaults, reg_addr 0x12, wr_data 0x80, slave ACKs → sio_d bytes 0x42,0x12,0x80; done at 465 cycles; ack_err 0.
- Same write, slave leaves sio_d high on data-phase 9th bit → ack_err 1 at done, transaction still completes.
- REG_AW=16, reg_addr 0x3008, wr_data 0x82 → bytes 0x42,0x30,0x08,0x82; done at 609 cycles.
- SCCB_READ_EN, read 0x0A, slave returns 0x76 → bytes 0x42,0x0A, STOP, gap, 0x43, NA=1; rd_data 0x76 at done (657 cycles).
- rst asserted at cycle 200 of a write → sio_c 1, sio_d Z, busy 0 immediately; following write to 0x11/0x01 completes normally.
- req held high continuously → back-to-back transactions, each done one pulse, second START begins cycle after first done; req pulses during busy ignored.
